// File: rtl/ddrx_ecc_err_pkg.sv
// Shared types for the ECC error tracker: scrub FSM encoding, beat classes
// and the saturating-increment helper used by every counter.
package ddrx_ecc_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } scrub_state_t;

  localparam logic [1:0] BEAT_NONE = 2'd0;
  localparam logic [1:0] BEAT_SBE  = 2'd1;
  localparam logic [1:0] BEAT_DBE  = 2'd2;

  // Counters are at most 32 bits wide; callers zero-extend in and truncate out.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ddrx_ecc_scrub_fifo.sv
// Small synchronous address FIFO feeding the scrub request FSM.
// A push while full is accepted only when a pop happens in the same cycle.
module ddrx_ecc_scrub_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             ctl_clk,
  input  logic             ctl_reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge ctl_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddrx_ecc_err_tracker.sv
// ECC error tracker: counts SBE/DBE beats, captures the worst error address,
// raises a sticky interrupt and issues scrub write-backs for corrected errors.
// Optional ECC_ERR_TRACKER_DEDUP_EN suppresses repeat pushes of the last address.
module ddrx_ecc_err_tracker
  import ddrx_ecc_err_pkg::*;
#(
  parameter int CFG_ADDR_WIDTH       = 32,
  parameter int CFG_ERR_CNT_WIDTH    = 8,
  parameter int CFG_SCRUB_FIFO_DEPTH = 4,
  parameter int CFG_SCRUB_HOLDOFF    = 3
) (
  input  logic                         ctl_clk,
  input  logic                         ctl_reset_n,
  input  logic                         cfg_enable_ecc,
  input  logic                         cfg_enable_intr,
  input  logic                         cfg_enable_auto_corr,
  input  logic                         cfg_clr_intr,
  input  logic                         cfg_clr_cnt,
  input  logic                         rd_valid,
  input  logic [CFG_ADDR_WIDTH-1:0]    rd_addr,
  input  logic                         err_corrected,
  input  logic                         err_detected,
  input  logic                         err_fatal,
  input  logic                         err_sbe,
  output logic [CFG_ERR_CNT_WIDTH-1:0] sbe_count,
  output logic [CFG_ERR_CNT_WIDTH-1:0] dbe_count,
  output logic [CFG_ERR_CNT_WIDTH-1:0] drop_count,
  output logic [CFG_ADDR_WIDTH-1:0]    err_addr,
  output logic                         err_addr_valid,
  output logic                         err_addr_is_dbe,
  output logic                         intr,
  output logic                         scrub_req,
  output logic [CFG_ADDR_WIDTH-1:0]    scrub_addr,
  input  logic                         scrub_ack,
  output logic                         scrub_busy
);

  localparam int HOLD_W = (CFG_SCRUB_HOLDOFF > 1) ? $clog2(CFG_SCRUB_HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    HOLD_W'((CFG_SCRUB_HOLDOFF > 0) ? CFG_SCRUB_HOLDOFF - 1 : 0);

  logic [1:0]                beat_q;
  logic [CFG_ADDR_WIDTH-1:0] addr_q;
  logic                      any_flag;
  logic                      beat_sbe;
  logic                      beat_dbe;
  logic                      beat_err;
  logic                      held_valid;
  logic                      push_req;
  logic                      push_dup;
  logic                      push_drop;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CFG_ADDR_WIDTH-1:0] fifo_head;
  scrub_state_t              state;
  logic [HOLD_W-1:0]         hold_cnt;

  // err_detected alone never classifies a beat; it only keeps flag-less beats out.
  assign any_flag = err_detected | err_corrected | err_fatal;

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      beat_q <= BEAT_NONE;
      addr_q <= '0;
    end else begin
      addr_q <= rd_addr;
      if (rd_valid && cfg_enable_ecc && any_flag) begin
        if (err_fatal)                    beat_q <= BEAT_DBE;
        else if (err_sbe && err_corrected) beat_q <= BEAT_SBE;
        else                              beat_q <= BEAT_NONE;
      end else begin
        beat_q <= BEAT_NONE;
      end
    end
  end

  assign beat_sbe   = (beat_q == BEAT_SBE);
  assign beat_dbe   = (beat_q == BEAT_DBE);
  assign beat_err   = beat_sbe | beat_dbe;
  assign held_valid = err_addr_valid & ~cfg_clr_intr;

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      sbe_count  <= '0;
      dbe_count  <= '0;
      drop_count <= '0;
    end else if (cfg_clr_cnt) begin
      sbe_count  <= '0;
      dbe_count  <= '0;
      drop_count <= '0;
    end else begin
      if (beat_sbe)
        sbe_count <= CFG_ERR_CNT_WIDTH'(sat_inc(32'(sbe_count), CFG_ERR_CNT_WIDTH));
      if (beat_dbe)
        dbe_count <= CFG_ERR_CNT_WIDTH'(sat_inc(32'(dbe_count), CFG_ERR_CNT_WIDTH));
      if (push_drop)
        drop_count <= CFG_ERR_CNT_WIDTH'(sat_inc(32'(drop_count), CFG_ERR_CNT_WIDTH));
    end
  end

  // A fatal error may replace a held SBE capture; a clear in the same cycle loses to a new error.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      err_addr        <= '0;
      err_addr_valid  <= 1'b0;
      err_addr_is_dbe <= 1'b0;
      intr            <= 1'b0;
    end else begin
      if (beat_err && (!held_valid || (beat_dbe && !err_addr_is_dbe))) begin
        err_addr        <= addr_q;
        err_addr_valid  <= 1'b1;
        err_addr_is_dbe <= beat_dbe;
      end else if (cfg_clr_intr) begin
        err_addr_valid  <= 1'b0;
      end
      if (beat_err && cfg_enable_intr) intr <= 1'b1;
      else if (cfg_clr_intr)           intr <= 1'b0;
    end
  end

  assign push_req = beat_sbe & cfg_enable_auto_corr;

`ifdef ECC_ERR_TRACKER_DEDUP_EN
  logic [CFG_ADDR_WIDTH-1:0] last_addr;
  logic                      last_valid;

  assign push_dup = last_valid && (last_addr == addr_q);

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else if (cfg_clr_cnt) begin
      last_valid <= 1'b0;
    end else if (fifo_push) begin
      last_addr  <= addr_q;
      last_valid <= 1'b1;
    end
  end
`else
  assign push_dup = 1'b0;
`endif

  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign fifo_push = push_req && !push_dup && (!fifo_full || fifo_pop);
  assign push_drop = push_req && !push_dup && fifo_full && !fifo_pop;

  ddrx_ecc_scrub_fifo #(
    .WIDTH (CFG_ADDR_WIDTH),
    .DEPTH (CFG_SCRUB_FIFO_DEPTH)
  ) u_scrub_fifo (
    .ctl_clk     (ctl_clk),
    .ctl_reset_n (ctl_reset_n),
    .push        (fifo_push),
    .push_data   (addr_q),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // HOLD spends exactly CFG_SCRUB_HOLDOFF cycles before IDLE may pop again.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state      <= ST_IDLE;
      scrub_req  <= 1'b0;
      scrub_addr <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state      <= ST_REQ;
            scrub_req  <= 1'b1;
            scrub_addr <= fifo_head;
          end
        end
        ST_REQ: begin
          if (scrub_ack) begin
            scrub_req <= 1'b0;
            if (CFG_SCRUB_HOLDOFF == 0) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_HOLD;
              hold_cnt <= HOLD_INIT;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) state <= ST_IDLE;
          else                hold_cnt <= hold_cnt - HOLD_W'(1);
        end
        default: begin
          state     <= ST_IDLE;
          scrub_req <= 1'b0;
        end
      endcase
    end
  end

  assign scrub_busy = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_ddrx_ecc_err_tracker.sv
// Self-checking bench for ddrx_ecc_err_tracker: directed scenarios plus random
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_ddrx_ecc_err_tracker;

  localparam int AW      = 32;
  localparam int CW      = 8;
  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 3;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef ECC_ERR_TRACKER_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  localparam int K_NONE = 0;
  localparam int K_SBE  = 1;
  localparam int K_DBE  = 2;

  logic          ctl_clk;
  logic          ctl_reset_n;
  logic          cfg_enable_ecc, cfg_enable_intr, cfg_enable_auto_corr;
  logic          cfg_clr_intr, cfg_clr_cnt;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          err_corrected, err_detected, err_fatal, err_sbe;
  logic [CW-1:0] sbe_count, dbe_count, drop_count;
  logic [AW-1:0] err_addr;
  logic          err_addr_valid, err_addr_is_dbe, intr;
  logic          scrub_req;
  logic [AW-1:0] scrub_addr;
  logic          scrub_ack;
  logic          scrub_busy;

  int checks = 0;
  int errors = 0;

  ddrx_ecc_err_tracker #(
    .CFG_ADDR_WIDTH       (AW),
    .CFG_ERR_CNT_WIDTH    (CW),
    .CFG_SCRUB_FIFO_DEPTH (DEPTH),
    .CFG_SCRUB_HOLDOFF    (HOLDOFF)
  ) dut (
    .ctl_clk              (ctl_clk),
    .ctl_reset_n          (ctl_reset_n),
    .cfg_enable_ecc       (cfg_enable_ecc),
    .cfg_enable_intr      (cfg_enable_intr),
    .cfg_enable_auto_corr (cfg_enable_auto_corr),
    .cfg_clr_intr         (cfg_clr_intr),
    .cfg_clr_cnt          (cfg_clr_cnt),
    .rd_valid             (rd_valid),
    .rd_addr              (rd_addr),
    .err_corrected        (err_corrected),
    .err_detected         (err_detected),
    .err_fatal            (err_fatal),
    .err_sbe              (err_sbe),
    .sbe_count            (sbe_count),
    .dbe_count            (dbe_count),
    .drop_count           (drop_count),
    .err_addr             (err_addr),
    .err_addr_valid       (err_addr_valid),
    .err_addr_is_dbe      (err_addr_is_dbe),
    .intr                 (intr),
    .scrub_req            (scrub_req),
    .scrub_addr           (scrub_addr),
    .scrub_ack            (scrub_ack),
    .scrub_busy           (scrub_busy)
  );

  initial ctl_clk = 1'b0;
  always #5 ctl_clk = ~ctl_clk;

  // Behavioural model state: plain integers, a queue for the FIFO and a cool-down counter.
  int            m_sbe, m_dbe, m_drop;
  logic [AW-1:0] m_err_addr;
  bit            m_valid, m_isdbe, m_intr;
  logic [AW-1:0] m_fifo[$];
  bit            m_req;
  logic [AW-1:0] m_scrub_addr;
  int            m_gap;
  bit            m_last_v;
  logic [AW-1:0] m_last_a;
  int            m_p_cls;
  logic [AW-1:0] m_p_addr;
  logic [AW-1:0] issued[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_sbe = 0; m_dbe = 0; m_drop = 0;
    m_err_addr = '0; m_valid = 0; m_isdbe = 0; m_intr = 0;
    m_fifo.delete();
    m_req = 0; m_scrub_addr = '0; m_gap = 0;
    m_last_v = 0; m_last_a = '0;
    m_p_cls = K_NONE; m_p_addr = '0;
  endtask

  task automatic modelStep();
    int cls, ncls;
    logic [AW-1:0] a;
    bit pop, want, dup, acc, drop;
    cls = m_p_cls;
    a   = m_p_addr;
    ncls = K_NONE;
    if (rd_valid && cfg_enable_ecc) begin
      if (err_fatal)                     ncls = K_DBE;
      else if (err_sbe && err_corrected) ncls = K_SBE;
    end
    pop  = !m_req && (m_gap == 0) && (m_fifo.size() > 0);
    want = (cls == K_SBE) && cfg_enable_auto_corr;
    dup  = DEDUP && m_last_v && (m_last_a == a);
    acc  = want && !dup && ((m_fifo.size() < DEPTH) || pop);
    drop = want && !dup && !acc;
    if (cfg_clr_cnt) begin
      m_sbe = 0; m_dbe = 0; m_drop = 0; m_last_v = 0;
    end else begin
      if (cls == K_SBE) m_sbe  = (m_sbe  < CNT_MAX) ? m_sbe  + 1 : CNT_MAX;
      if (cls == K_DBE) m_dbe  = (m_dbe  < CNT_MAX) ? m_dbe  + 1 : CNT_MAX;
      if (drop)         m_drop = (m_drop < CNT_MAX) ? m_drop + 1 : CNT_MAX;
      if (acc) begin m_last_v = 1; m_last_a = a; end
    end
    if (pop) begin
      m_scrub_addr = m_fifo.pop_front();
      m_req = 1;
    end else if (m_req && scrub_ack) begin
      m_req = 0;
      m_gap = HOLDOFF;
    end else if (!m_req && m_gap > 0) begin
      m_gap--;
    end
    if (acc) m_fifo.push_back(a);
    if (cls != K_NONE && (!(m_valid && !cfg_clr_intr) || (cls == K_DBE && !m_isdbe))) begin
      m_err_addr = a; m_valid = 1; m_isdbe = (cls == K_DBE);
    end else if (cfg_clr_intr) begin
      m_valid = 0;
    end
    if (cls != K_NONE && cfg_enable_intr) m_intr = 1;
    else if (cfg_clr_intr)                m_intr = 0;
    m_p_cls  = ncls;
    m_p_addr = rd_addr;
  endtask

  // Single compare process: advance the model on each edge, check the DUT 1ns later.
  always @(posedge ctl_clk) begin
    if (!ctl_reset_n) begin
      modelReset();
    end else begin
      if (scrub_req && scrub_ack) issued.push_back(scrub_addr);
      modelStep();
    end
    #1;
    if (ctl_reset_n) begin
      checkOutput("sbe_count",  64'(sbe_count),       64'(m_sbe));
      checkOutput("dbe_count",  64'(dbe_count),       64'(m_dbe));
      checkOutput("drop_count", 64'(drop_count),      64'(m_drop));
      checkOutput("err_addr",   64'(err_addr),        64'(m_err_addr));
      checkOutput("addr_valid", 64'(err_addr_valid),  64'(m_valid));
      checkOutput("addr_isdbe", 64'(err_addr_is_dbe), 64'(m_isdbe));
      checkOutput("intr",       64'(intr),            64'(m_intr));
      checkOutput("scrub_req",  64'(scrub_req),       64'(m_req));
      checkOutput("scrub_addr", 64'(scrub_addr),      64'(m_scrub_addr));
      checkOutput("scrub_busy", 64'(scrub_busy),
                  64'(m_req || (m_gap > 0) || (m_fifo.size() > 0)));
    end
  end

  task automatic applyStimulus(input int kind, input logic [AW-1:0] addr);
    rd_valid      = (kind != K_NONE);
    rd_addr       = addr;
    err_fatal     = (kind == K_DBE);
    err_sbe       = (kind == K_SBE);
    err_corrected = (kind == K_SBE);
    err_detected  = (kind != K_NONE);
    @(negedge ctl_clk);
    rd_valid = 0; err_fatal = 0; err_sbe = 0; err_corrected = 0; err_detected = 0;
  endtask

  task automatic clearAll();
    cfg_clr_intr = 1; cfg_clr_cnt = 1;
    @(negedge ctl_clk);
    cfg_clr_intr = 0; cfg_clr_cnt = 0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((scrub_busy || scrub_req) && n < 300) begin
      @(negedge ctl_clk);
      n++;
    end
    checkOutput(name, 64'(scrub_busy), 64'(0));
  endtask

  initial begin
    ctl_reset_n = 0;
    cfg_enable_ecc = 1; cfg_enable_intr = 1; cfg_enable_auto_corr = 1;
    cfg_clr_intr = 0; cfg_clr_cnt = 0;
    rd_valid = 0; rd_addr = '0;
    err_corrected = 0; err_detected = 0; err_fatal = 0; err_sbe = 0;
    scrub_ack = 1;
    repeat (3) @(negedge ctl_clk);
    ctl_reset_n = 1;
    @(negedge ctl_clk);
    checkOutput("rst_sbe",   64'(sbe_count),  64'(0));
    checkOutput("rst_intr",  64'(intr),       64'(0));
    checkOutput("rst_req",   64'(scrub_req),  64'(0));
    checkOutput("rst_busy",  64'(scrub_busy), 64'(0));

    // 1: single SBE, ack held high
    applyStimulus(K_SBE, 32'h100);
    @(negedge ctl_clk);
    checkOutput("t1_sbe",    64'(sbe_count),       64'(1));
    checkOutput("t1_addr",   64'(err_addr),        64'h100);
    checkOutput("t1_isdbe",  64'(err_addr_is_dbe), 64'(0));
    checkOutput("t1_intr",   64'(intr),            64'(1));
    checkOutput("t1_noreq",  64'(scrub_req),       64'(0));
    @(negedge ctl_clk);
    checkOutput("t1_req",    64'(scrub_req),       64'(1));
    checkOutput("t1_saddr",  64'(scrub_addr),      64'h100);
    for (int i = 0; i < HOLDOFF; i++) begin
      @(negedge ctl_clk);
      checkOutput("t1_hold",  64'(scrub_busy), 64'(1));
      checkOutput("t1_hreq",  64'(scrub_req),  64'(0));
    end
    @(negedge ctl_clk);
    checkOutput("t1_idle", 64'(scrub_busy), 64'(0));

    // 2: SBE then DBE
    clearAll();
    applyStimulus(K_SBE, 32'h200);
    applyStimulus(K_DBE, 32'h300);
    @(negedge ctl_clk);
    checkOutput("t2_addr",  64'(err_addr),        64'h300);
    checkOutput("t2_isdbe", 64'(err_addr_is_dbe), 64'(1));
    checkOutput("t2_dbe",   64'(dbe_count),       64'(1));
    checkOutput("t2_sbe",   64'(sbe_count),       64'(1));
    waitIdle("t2_drain");

    // 3: overflow with ack low, then in-order drain
    clearAll();
    scrub_ack = 0;
    for (int i = 0; i < 6; i++) applyStimulus(K_SBE, 32'h1000 + 32'(i * 16));
    repeat (2) @(negedge ctl_clk);
    checkOutput("t3_drop",  64'(drop_count), 64'(1));
    checkOutput("t3_req",   64'(scrub_req),  64'(1));
    checkOutput("t3_saddr", 64'(scrub_addr), 64'h1000);
    issued.delete();
    scrub_ack = 1;
    waitIdle("t3_drain");
    checkOutput("t3_count", 64'(issued.size()), 64'(5));
    for (int k = 0; k < 5 && k < issued.size(); k++)
      checkOutput("t3_order", 64'(issued[k]), 64'(32'h1000 + 32'(k * 16)));

    // 4: saturation and clear-vs-increment
    clearAll();
    scrub_ack = 0;
    for (int i = 0; i < 300; i++) applyStimulus(K_SBE, 32'h2000 + 32'(i));
    @(negedge ctl_clk);
    checkOutput("t4_sbe_sat",  64'(sbe_count),  64'(255));
    checkOutput("t4_drop_sat", 64'(drop_count), 64'(255));
    applyStimulus(K_SBE, 32'h3000);
    cfg_clr_cnt = 1;
    @(negedge ctl_clk);
    cfg_clr_cnt = 0;
    checkOutput("t4_clr_sbe",  64'(sbe_count),  64'(0));
    checkOutput("t4_clr_drop", 64'(drop_count), 64'(0));
    scrub_ack = 1;
    waitIdle("t4_drain");

    // 5: clr_intr colliding with a DBE capture, then held DBE vs later SBE
    clearAll();
    applyStimulus(K_SBE, 32'h480);
    @(negedge ctl_clk);
    applyStimulus(K_DBE, 32'h500);
    cfg_clr_intr = 1;
    @(negedge ctl_clk);
    cfg_clr_intr = 0;
    checkOutput("t5_intr",  64'(intr),            64'(1));
    checkOutput("t5_addr",  64'(err_addr),        64'h500);
    checkOutput("t5_valid", 64'(err_addr_valid),  64'(1));
    checkOutput("t5_isdbe", 64'(err_addr_is_dbe), 64'(1));
    cfg_clr_intr = 1;
    @(negedge ctl_clk);
    cfg_clr_intr = 0;
    checkOutput("t5_intr_clr",  64'(intr),           64'(0));
    checkOutput("t5_valid_clr", 64'(err_addr_valid), 64'(0));
    applyStimulus(K_DBE, 32'h600);
    applyStimulus(K_SBE, 32'h700);
    @(negedge ctl_clk);
    checkOutput("t5_keep_dbe", 64'(err_addr),  64'h600);
    checkOutput("t5_sbe2",     64'(sbe_count), 64'(2));
    checkOutput("t5_dbe2",     64'(dbe_count), 64'(2));
    waitIdle("t5_drain");

    // 6: repeated address burst
    clearAll();
    issued.delete();
    for (int i = 0; i < 4; i++) applyStimulus(K_SBE, 32'h400);
    repeat (3) @(negedge ctl_clk);
    waitIdle("t6_drain");
    checkOutput("t6_reqs", 64'(issued.size()), DEDUP ? 64'(1) : 64'(4));
    checkOutput("t6_drop", 64'(drop_count),    64'(0));

    // ECC disabled: beats ignored
    clearAll();
    cfg_enable_ecc = 0;
    applyStimulus(K_DBE, 32'hA00);
    repeat (2) @(negedge ctl_clk);
    checkOutput("ecc_off_dbe",  64'(dbe_count), 64'(0));
    checkOutput("ecc_off_intr", 64'(intr),      64'(0));
    cfg_enable_ecc = 1;

    // Random traffic, model checked every cycle
    for (int i = 0; i < 3000; i++) begin
      rd_valid      = ($urandom_range(0, 99) < 60);
      err_fatal     = ($urandom_range(0, 9) == 0);
      err_sbe       = ($urandom_range(0, 2) != 0);
      err_corrected = ($urandom_range(0, 3) != 0);
      err_detected  = ($urandom_range(0, 1) == 1);
      rd_addr       = 32'h40 + 32'($urandom_range(0, 5));
      scrub_ack     = ($urandom_range(0, 9) < 6);
      cfg_clr_intr  = ($urandom_range(0, 49) == 0);
      cfg_clr_cnt   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) cfg_enable_ecc       = ~cfg_enable_ecc;
      if ($urandom_range(0, 99) == 0) cfg_enable_intr      = ~cfg_enable_intr;
      if ($urandom_range(0, 99) == 0) cfg_enable_auto_corr = ~cfg_enable_auto_corr;
      @(negedge ctl_clk);
    end
    rd_valid = 0; err_fatal = 0; err_sbe = 0; err_corrected = 0; err_detected = 0;
    cfg_clr_intr = 0; cfg_clr_cnt = 0;
    cfg_enable_ecc = 1; cfg_enable_intr = 1; cfg_enable_auto_corr = 1;
    scrub_ack = 1;
    waitIdle("rnd_drain");

    // Async reset in the middle of a request
    clearAll();
    scrub_ack = 0;
    applyStimulus(K_SBE, 32'h900);
    applyStimulus(K_SBE, 32'h910);
    repeat (2) @(negedge ctl_clk);
    checkOutput("mr_req_on", 64'(scrub_req), 64'(1));
    ctl_reset_n = 0;
    #1;
    checkOutput("mr_req_off",  64'(scrub_req),  64'(0));
    checkOutput("mr_busy_off", 64'(scrub_busy), 64'(0));
    checkOutput("mr_sbe_off",  64'(sbe_count),  64'(0));
    repeat (2) @(negedge ctl_clk);
    ctl_reset_n = 1;
    scrub_ack = 1;
    repeat (5) @(negedge ctl_clk);
    checkOutput("mr_flushed", 64'(scrub_busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
